// File: rtl/md_pkg.sv
// md_pkg: shared op/mf encodings, MIPS opcode/funct constants and latency defaults
package md_pkg;
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADDU = 4'd7;
    localparam logic [3:0] MD_MSUBU = 4'd8;

    localparam logic [1:0] MF_NONE = 2'b00;
    localparam logic [1:0] MF_HI   = 2'b01;
    localparam logic [1:0] MF_LO   = 2'b10;

    localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
    localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MADDU = 6'b000001;
    localparam logic [5:0] FN_MSUBU = 6'b000101;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
endpackage

// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if: D-stage inputs and E-stage/hazard outputs of the muldiv issue controller
interface md_issue_ctrl_if;
    logic [31:0] instr_d;
    logic        stall_other_i;
    logic        md_busy_i;
    logic [3:0]  md_op_e;
    logic        md_start_e;
    logic [1:0]  mf_sel_e;
    logic        stall_md;
    logic        mismatch_o;

    modport master (
        output instr_d, stall_other_i, md_busy_i,
        input  md_op_e, md_start_e, mf_sel_e, stall_md, mismatch_o
    );
    modport slave (
        input  instr_d, stall_other_i, md_busy_i,
        output md_op_e, md_start_e, mf_sel_e, stall_md, mismatch_o
    );
endinterface

// File: rtl/md_decode.sv
// md_decode: maps a D-stage instruction to its muldiv op, HI/LO read select and md_d flag
module md_decode
    import md_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [3:0]  op_o,
    output logic [1:0]  mf_sel_o,
    output logic        md_d_o
);
    logic [5:0] opc, fn;
    logic       unused_fields;

    assign opc = instr_i[31:26];
    assign fn  = instr_i[5:0];
    assign unused_fields = ^instr_i[25:6];

    always_comb begin
        op_o     = MD_NONE;
        mf_sel_o = MF_NONE;
        if (opc == OPC_SPECIAL) begin
            case (fn)
                FN_MULT:  op_o = MD_MULT;
                FN_MULTU: op_o = MD_MULTU;
                FN_DIV:   op_o = MD_DIV;
                FN_DIVU:  op_o = MD_DIVU;
                FN_MTHI:  op_o = MD_MTHI;
                FN_MTLO:  op_o = MD_MTLO;
                FN_MFHI:  mf_sel_o = MF_HI;
                FN_MFLO:  mf_sel_o = MF_LO;
                default:  op_o = MD_NONE;
            endcase
        end else if (opc == OPC_SPECIAL2) begin
            op_o = (fn == FN_MADDU) ? MD_MADDU : (fn == FN_MSUBU) ? MD_MSUBU : MD_NONE;
        end
    end

    assign md_d_o = (op_o != MD_NONE) | (mf_sel_o != MF_NONE);
endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: registers decoded muldiv ops into E, shadows unit latency and
// stalls D-stage HI/LO instructions that would collide with a running op.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input logic           clk,
    input logic           reset,
    md_issue_ctrl_if.slave bus
);
    logic [3:0] op_d, op_e_q, cnt_q, cnt_d;
    logic [1:0] mf_d, mf_e_q;
    logic       md_d, start_prev_q, mismatch_q, is_mul, is_div;

    md_decode u_decode (
        .instr_i  (bus.instr_d),
        .op_o     (op_d),
        .mf_sel_o (mf_d),
        .md_d_o   (md_d)
    );

    assign is_mul = (op_e_q == MD_MULT) | (op_e_q == MD_MULTU);
    assign is_div = (op_e_q == MD_DIV) | (op_e_q == MD_DIVU);

    assign bus.md_op_e    = op_e_q;
    assign bus.mf_sel_e   = mf_e_q;
    assign bus.md_start_e = is_mul | is_div;
    assign bus.mismatch_o = mismatch_q;
    // one cycle conservative: blocks while the start is still sitting in E
    assign bus.stall_md   = md_d & (bus.md_start_e | (cnt_q != 4'd0));

    always_comb
        cnt_d = is_mul ? 4'(MUL_LAT) : is_div ? 4'(DIV_LAT) : cnt_q - 4'(cnt_q != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            op_e_q       <= MD_NONE;
            mf_e_q       <= MF_NONE;
            cnt_q        <= 4'd0;
            start_prev_q <= 1'b0;
            mismatch_q   <= 1'b0;
        end else begin
            op_e_q       <= (bus.stall_md | bus.stall_other_i) ? MD_NONE : op_d;
            mf_e_q       <= (bus.stall_md | bus.stall_other_i) ? MF_NONE : mf_d;
            cnt_q        <= cnt_d;
            start_prev_q <= bus.md_start_e;
            mismatch_q   <= mismatch_q | (bus.md_busy_i & (cnt_q == 4'd0) & ~start_prev_q);
        end
    end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed stimulus with a timestamp-based latency model checked every cycle
module tb_md_issue_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    md_issue_ctrl_if bus();
    md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [31:0] I_MULT  = 32'h0085_0018;
    localparam logic [31:0] I_DIV   = 32'h0085_001A;
    localparam logic [31:0] I_DIVU  = 32'h0085_001B;
    localparam logic [31:0] I_MTHI  = 32'h0080_0011;
    localparam logic [31:0] I_MFHI  = 32'h0000_1010;
    localparam logic [31:0] I_MFLO  = 32'h0000_1012;
    localparam logic [31:0] I_MADDU = 32'h7085_0001;
    localparam logic [31:0] I_MSUBU = 32'h7085_0005;
    localparam logic [31:0] I_ADD   = 32'h0085_1020;

    int checks = 0, fails = 0;
    int cyc = 0, zero_at = 0;
    logic [3:0] m_op = 4'd0;
    logic [1:0] m_mf = 2'd0;
    logic m_mism = 1'b0, m_prev = 1'b0, live = 1'b0, force_busy = 1'b0;

    // table lookup on {opcode, funct}: returns {op, mf}
    function automatic logic [5:0] dec(input logic [31:0] i);
        logic [11:0] k;
        k = {i[31:26], i[5:0]};
        case (k)
            12'h018: return {4'd1, 2'd0};
            12'h019: return {4'd2, 2'd0};
            12'h01A: return {4'd3, 2'd0};
            12'h01B: return {4'd4, 2'd0};
            12'h011: return {4'd5, 2'd0};
            12'h013: return {4'd6, 2'd0};
            12'h010: return {4'd0, 2'd1};
            12'h012: return {4'd0, 2'd2};
            12'h701: return {4'd7, 2'd0};
            12'h705: return {4'd8, 2'd0};
            default: return 6'd0;
        endcase
    endfunction

    function automatic int cnt_now();
        return (zero_at > cyc) ? zero_at - cyc : 0;
    endfunction

    function automatic logic starts(input logic [3:0] op);
        return op >= 4'd1 && op <= 4'd4;
    endfunction

    function automatic logic m_stall();
        return (dec(bus.instr_d) != 6'd0) && (starts(m_op) || cnt_now() != 0);
    endfunction

    always @(posedge clk) begin
        logic [5:0] d;
        logic st;
        if (reset) begin
            m_op = 0; m_mf = 0; zero_at = 0; m_mism = 0; m_prev = 0; live = 1;
        end else begin
            m_mism = m_mism | (bus.md_busy_i && cnt_now() == 0 && !m_prev);
            m_prev = starts(m_op);
            st = m_stall() || bus.stall_other_i;
            if (m_op == 1 || m_op == 2) zero_at = cyc + 1 + 5;
            else if (m_op == 3 || m_op == 4) zero_at = cyc + 1 + 10;
            d = dec(bus.instr_d);
            m_op = st ? 4'd0 : d[5:2];
            m_mf = st ? 2'd0 : d[1:0];
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        logic [8:0] exp_v, act_v;
        if (live) begin
            exp_v = {m_op, starts(m_op), m_mf, m_stall(), m_mism};
            act_v = {bus.md_op_e, bus.md_start_e, bus.mf_sel_e, bus.stall_md, bus.mismatch_o};
            checks++;
            if (exp_v !== act_v) begin
                fails++;
                $display("FAIL cycle %0d {op,start,mf,stall,mism}: got %b want %b", cyc, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.md_busy_i = force_busy | (cnt_now() != 0);
    endtask

    task automatic idle(input int n);
        bus.instr_d = 32'h0;
        repeat (n) tick();
    endtask

    // hold ins in D until it issues; s = number of stalled cycles
    task automatic issue(input logic [31:0] ins, output int s);
        logic done;
        bus.instr_d = ins;
        s = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!bus.stall_md && !bus.stall_other_i) done = 1;
            else s++;
            tick();
        end
        if (!done) chk("issue_timeout", 0, 1);
        bus.instr_d = 32'h0;
    endtask

    initial begin
        int s;
        bus.instr_d = 0; bus.stall_other_i = 0; bus.md_busy_i = 0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_op", bus.md_op_e, 0);
        chk("reset_mism", bus.mismatch_o, 0);

        issue(I_MULT, s);  chk("mult_stall", s, 0);  chk("mult_op", bus.md_op_e, 1);
        issue(I_MFLO, s);  chk("mflo_stall", s, 6);  chk("mflo_sel", bus.mf_sel_e, 2);
        idle(2);
        issue(I_DIVU, s);  chk("divu_stall", s, 0);  chk("divu_op", bus.md_op_e, 4);
        issue(I_MFHI, s);  chk("mfhi_stall", s, 11); chk("mfhi_sel", bus.mf_sel_e, 1);
        idle(3);
        issue(I_MTHI, s);  chk("mthi_stall", s, 0);  chk("mthi_op", bus.md_op_e, 5);
        chk("mthi_start", bus.md_start_e, 0);
        idle(1);           chk("mthi_one_cycle", bus.md_op_e, 0); chk("mthi_cnt", cnt_now(), 0);

        issue(I_MULT, s);
        issue(I_DIV, s);   chk("div_after_mult", s, 6); chk("div_op", bus.md_op_e, 3);
        issue(I_ADD, s);   chk("add_no_stall", s, 0);  chk("div_cnt", cnt_now(), 10);
        idle(12);
        issue(I_MULT, s);
        issue(I_MADDU, s); chk("maddu_stall", s, 6); chk("maddu_op", bus.md_op_e, 7);
        issue(I_MSUBU, s); chk("msubu_stall", s, 0); chk("msubu_op", bus.md_op_e, 8);
        idle(2);

        bus.stall_other_i = 1; bus.instr_d = I_MULT;
        tick();            chk("other_bubble", bus.md_op_e, 0);
        bus.stall_other_i = 0;
        tick();            chk("other_issue", bus.md_op_e, 1);
        bus.instr_d = 0;
        tick();            chk("other_cnt", cnt_now(), 5);
        bus.instr_d = I_MFHI;
        @(negedge clk);    chk("busy_stall", bus.stall_md, 1);
        idle(8);

        issue(I_DIV, s);
        idle(4);           chk("pre_reset_cnt", cnt_now(), 7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_op", bus.md_op_e, 0); chk("rst_mism", bus.mismatch_o, 0); chk("rst_cnt", cnt_now(), 0);
        issue(I_MFLO, s);  chk("post_reset_mflo", s, 0); chk("post_reset_sel", bus.mf_sel_e, 2);
        idle(3);

        force_busy = 1; bus.md_busy_i = 1;
        tick();
        force_busy = 0; bus.md_busy_i = 0;
        chk("mism_set", bus.mismatch_o, 1);
        idle(2);           chk("mism_sticky", bus.mismatch_o, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mism_clear", bus.mismatch_o, 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
